// File: rtl/mem_port_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_scheduler_pkg
//   Shared definitions for the main-memory port scheduler:
//   - FSM state encoding (IDLE=0, GRANT=1, RELEASE=2)
//   - ceil-log2 helper (minimum result 1) used to size IDs and counters
//   - default grant-hold limit for the optional timeout
// -----------------------------------------------------------------------------
package mem_port_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } sched_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  // Bits needed to hold values 0..value-1; never less than 1.
  function automatic int log2c(input int value);
    int bits;
    bits = 1;
    for (int b = 1; b < 31; b++) begin
      if ((1 << b) < value) bits = b + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/request_order_queue.sv
// -----------------------------------------------------------------------------
// request_order_queue
//   Circular queue of channel IDs in arrival order. Several channels may be
//   enqueued on the same edge (written in ascending index order); one entry
//   may be popped per edge. Each channel holds at most one entry, so the
//   queue (depth NUM_CACHES) cannot overflow.
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-low reset (empties the queue)
//   enq      in   NUM_CACHES  channels to append this edge (must not be queued)
//   pop      in   remove head this edge (caller only pops when !empty)
//   head_id  out  ID_BITS     channel at the head of the queue
//   empty    out  queue holds no entries
//   count    out  ID_BITS+1   number of entries
//   queued   out  NUM_CACHES  per-channel "has an entry" bitmap
// -----------------------------------------------------------------------------
module request_order_queue
  import mem_port_scheduler_pkg::*;
#(
  parameter int  NUM_CACHES = 4,
  localparam int ID_BITS    = log2c(NUM_CACHES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_CACHES-1:0] enq,
  input  logic                  pop,
  output logic [ID_BITS-1:0]    head_id,
  output logic                  empty,
  output logic [ID_BITS:0]      count,
  output logic [NUM_CACHES-1:0] queued
);

  logic [ID_BITS-1:0]    entry_q [NUM_CACHES];
  logic [ID_BITS-1:0]    entry_d [NUM_CACHES];
  logic [ID_BITS-1:0]    head_q;
  logic [ID_BITS-1:0]    tail_q;
  logic [ID_BITS-1:0]    tail_d;
  logic [ID_BITS:0]      count_q;
  logic [ID_BITS:0]      n_enq;
  logic [NUM_CACHES-1:0] queued_q;
  logic [NUM_CACHES-1:0] pop_mask;

  // Pointer advance with an explicit wrap so non-power-of-2 depths work.
  function automatic logic [ID_BITS-1:0] ptr_inc(input logic [ID_BITS-1:0] p);
    if (p == ID_BITS'(NUM_CACHES - 1)) return '0;
    return p + ID_BITS'(1);
  endfunction

  assign head_id = entry_q[head_q];
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign queued  = queued_q;

  // Walk the request vector low to high so same-edge arrivals land in
  // ascending index order starting at the current tail.
  always_comb begin
    logic [ID_BITS-1:0] ptr;
    ptr     = tail_q;
    n_enq   = '0;
    entry_d = entry_q;
    for (int i = 0; i < NUM_CACHES; i++) begin
      if (enq[i]) begin
        entry_d[ptr] = ID_BITS'(i);
        ptr          = ptr_inc(ptr);
        n_enq        = n_enq + (ID_BITS + 1)'(1);
      end
    end
    tail_d = ptr;
  end

  always_comb begin
    pop_mask = '0;
    if (pop) pop_mask[head_id] = 1'b1;
  end

  // ---- storage boundary: entry contents are only meaningful between head
  // and tail, so they carry no reset ----
  always_ff @(posedge clock) begin
    entry_q <= entry_d;
  end

  // ---- control boundary: pointers, occupancy and bitmap ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      queued_q <= '0;
    end else begin
      tail_q   <= tail_d;
      if (pop) head_q <= ptr_inc(head_q);
      count_q  <= count_q + n_enq - (ID_BITS + 1)'(pop);
      queued_q <= (queued_q & ~pop_mask) | enq;
    end
  end

endmodule

// File: rtl/mem_port_scheduler.sv
// -----------------------------------------------------------------------------
// mem_port_scheduler
//   Shares the single main-memory port among NUM_CACHES cache channels in
//   strict arrival order. A channel is granted until memory pulses done,
//   then one turnaround cycle (RELEASE) separates consecutive grants.
//   A channel still requesting after its grant re-enters at the queue tail.
//
//   Optional feature macro: MEM_SCHED_TIMEOUT_EN
//     When defined, a grant held TIMEOUT_CYCLES cycles without done is
//     revoked, timeout_err pulses for one cycle, and the revoked channel is
//     ignored until its req drops and rises again.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   req          in   NUM_CACHES  level request per channel
//   done         in   one-cycle pulse from memory ending the current access
//   grant        out  NUM_CACHES  one-hot grant (registered)
//   grant_valid  out  any grant active (registered)
//   grant_id     out  ID_BITS     index of granted channel, 0 when none
//   queue_count  out  ID_BITS+1   channels waiting (excludes granted one)
//   timeout_err  out  forced-revoke pulse (MEM_SCHED_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module mem_port_scheduler
  import mem_port_scheduler_pkg::*;
#(
  parameter int  NUM_CACHES     = 4,
  parameter int  TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int ID_BITS        = log2c(NUM_CACHES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_CACHES-1:0] req,
  input  logic                  done,
  output logic [NUM_CACHES-1:0] grant,
  output logic                  grant_valid,
  output logic [ID_BITS-1:0]    grant_id,
  output logic [ID_BITS:0]      queue_count
`ifdef MEM_SCHED_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);

  sched_state_t          state_q;
  sched_state_t          state_d;
  logic [NUM_CACHES-1:0] grant_d;
  logic [ID_BITS-1:0]    grant_id_d;
  logic                  grant_valid_d;
  logic                  pop;
  logic [NUM_CACHES-1:0] enq_mask;
  logic [ID_BITS-1:0]    head_id;
  logic                  q_empty;
  logic [NUM_CACHES-1:0] queued;

`ifdef MEM_SCHED_TIMEOUT_EN
  localparam int               CNT_W     = log2c(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]      hold_cnt;
  logic [NUM_CACHES-1:0] blocked;
  logic                  revoke;

  // A revoked channel stays out of the queue until it withdraws its request.
  assign enq_mask = req & ~queued & ~grant & ~blocked;
`else
  // Timeout support compiled out; the limit is accepted but has no effect.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign enq_mask = req & ~queued & ~grant;
`endif

  request_order_queue #(
    .NUM_CACHES (NUM_CACHES)
  ) u_order_queue (
    .clock   (clock),
    .reset   (reset),
    .enq     (enq_mask),
    .pop     (pop),
    .head_id (head_id),
    .empty   (q_empty),
    .count   (queue_count),
    .queued  (queued)
  );

  // Next-state and next-grant decode.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant;
    grant_id_d    = grant_id;
    grant_valid_d = grant_valid;
    pop           = 1'b0;
`ifdef MEM_SCHED_TIMEOUT_EN
    revoke        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // The head is popped either way; a head whose requester has gone
        // away is simply dropped and costs this cycle.
        if (!q_empty) begin
          pop = 1'b1;
          if (req[head_id]) begin
            state_d          = GRANT;
            grant_d          = '0;
            grant_d[head_id] = 1'b1;
            grant_id_d       = head_id;
            grant_valid_d    = 1'b1;
          end
        end
      end
      GRANT: begin
        if (done) begin
          state_d       = RELEASE;
          grant_d       = '0;
          grant_id_d    = '0;
          grant_valid_d = 1'b0;
        end
`ifdef MEM_SCHED_TIMEOUT_EN
        else if (hold_cnt == HOLD_LAST) begin
          state_d       = RELEASE;
          grant_d       = '0;
          grant_id_d    = '0;
          grant_valid_d = 1'b0;
          revoke        = 1'b1;
        end
`endif
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d       = IDLE;
        grant_d       = '0;
        grant_id_d    = '0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // ---- grant register boundary ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      state_q     <= state_d;
      grant       <= grant_d;
      grant_valid <= grant_valid_d;
      grant_id    <= grant_id_d;
    end
  end

`ifdef MEM_SCHED_TIMEOUT_EN
  // ---- hold counter boundary: counts completed grant cycles, zero outside
  // GRANT so each new grant starts from 0 ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_cnt    <= '0;
      blocked     <= '0;
      timeout_err <= 1'b0;
    end else begin
      hold_cnt    <= (state_q == GRANT) ? hold_cnt + CNT_W'(1) : '0;
      blocked     <= (blocked & req) | (revoke ? grant : '0);
      timeout_err <= revoke;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mem_port_scheduler
//   Directed scenarios followed by randomized request/done traffic. Every
//   cycle the DUT outputs are compared with a behavioural model built from
//   an arrival-ordered list of channel numbers and the grant/turnaround
//   rules of the scheduler. Define MEM_SCHED_TIMEOUT_EN to also exercise
//   the forced-revoke path (TIMEOUT_CYCLES = 8).
// -----------------------------------------------------------------------------
module tb_mem_port_scheduler;

  localparam int N   = 4;
  localparam int TMO = 8;

  localparam int PH_IDLE = 0;
  localparam int PH_BUSY = 1;
  localparam int PH_TURN = 2;

  logic         clock;
  logic         reset;
  logic         done;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic [2:0]   queue_count;
`ifdef MEM_SCHED_TIMEOUT_EN
  logic         timeout_err;
`endif

  int    errors = 0;
  int    checks = 0;
  string phase_tag = "init";

  // Behavioural model state
  int m_q[$];      // waiting channels, oldest first
  int m_gnt;       // granted channel, -1 when none
  int m_phase;     // idle / busy / turnaround
  int m_held;      // grant cycles completed by current owner
  bit m_blk [N];   // channel revoked and waiting for its req to drop
  bit m_err;       // revoke happened on the last edge

  mem_port_scheduler #(
    .NUM_CACHES     (N),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .queue_count (queue_count)
`ifdef MEM_SCHED_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_queue(input int ch);
    foreach (m_q[k]) if (m_q[k] == ch) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_gnt   = -1;
    m_phase = PH_IDLE;
    m_held  = 0;
    m_err   = 1'b0;
    for (int i = 0; i < N; i++) m_blk[i] = 1'b0;
  endtask

  // One clock edge of the scheduler rules, using the inputs present at it.
  task automatic model_step();
    int newcomers[$];
    int head;
    m_err = 1'b0;
    for (int i = 0; i < N; i++)
      if (req[i] && !in_queue(i) && m_gnt != i && !m_blk[i]) newcomers.push_back(i);
    for (int i = 0; i < N; i++)
      if (!req[i]) m_blk[i] = 1'b0;
    if (m_phase == PH_IDLE) begin
      if (m_q.size() > 0) begin
        head = m_q.pop_front();
        if (req[head]) begin
          m_gnt   = head;
          m_phase = PH_BUSY;
          m_held  = 0;
        end
      end
    end else if (m_phase == PH_BUSY) begin
      m_held++;
      if (done) begin
        m_gnt   = -1;
        m_phase = PH_TURN;
      end
`ifdef MEM_SCHED_TIMEOUT_EN
      else if (m_held == TMO) begin
        m_blk[m_gnt] = 1'b1;
        m_gnt        = -1;
        m_phase      = PH_TURN;
        m_err        = 1'b1;
      end
`endif
    end else begin
      m_phase = PH_IDLE;
    end
    foreach (newcomers[k]) m_q.push_back(newcomers[k]);
  endtask

  task automatic compare_all();
    check({phase_tag, ".grant"}, 32'(grant),
          (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0);
    check({phase_tag, ".grant_valid"}, 32'(grant_valid), 32'(m_gnt >= 0));
    check({phase_tag, ".grant_id"}, 32'(grant_id),
          (m_gnt >= 0) ? 32'(m_gnt) : 32'd0);
    check({phase_tag, ".queue_count"}, 32'(queue_count), 32'(m_q.size()));
`ifdef MEM_SCHED_TIMEOUT_EN
    check({phase_tag, ".timeout_err"}, 32'(timeout_err), 32'(m_err));
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  // Tick until a grant appears; reports how many edges that took.
  task automatic wait_grant(input int budget, output int n);
    n = 0;
    while (!grant_valid && n < budget) begin
      tick();
      n++;
    end
    check({phase_tag, ".wait_grant"}, 32'(grant_valid), 32'd1);
  endtask

  // Current owner holds the port for len cycles, done in the last one.
  task automatic serve(input int len);
    done = 1'b0;
    repeat (len - 1) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // Asynchronous reset away from the clock edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check({phase_tag, ".rst_grant"}, 32'(grant), 32'd0);
    check({phase_tag, ".rst_grant_valid"}, 32'(grant_valid), 32'd0);
    check({phase_tag, ".rst_queue_count"}, 32'(queue_count), 32'd0);
    compare_all();
    #2;
    reset = 1'b1;
  endtask

  initial begin
    int n;
    req   = '0;
    done  = 1'b0;
    reset = 1'b1;
    model_reset();
    #3;
    phase_tag = "reset";
    do_reset();

    // Single requester, 5-cycle access
    phase_tag = "t1";
    req = 4'b0100;
    tick();
    check("t1.enq_count", 32'(queue_count), 32'd1);
    check("t1.no_grant_yet", 32'(grant), 32'd0);
    tick();
    check("t1.grant", 32'(grant), 32'h4);
    check("t1.grant_id", 32'(grant_id), 32'd2);
    req = 4'b0000;
    serve(5);
    check("t1.released", 32'(grant), 32'd0);
    tick();

    // All four at once, 3-cycle accesses
    phase_tag = "t2";
    req = 4'b1111;
    tick();
    check("t2.count4", 32'(queue_count), 32'd4);
    for (int k = 0; k < N; k++) begin
      wait_grant(4, n);
      check("t2.order", 32'(grant_id), 32'(k));
      check("t2.count", 32'(queue_count), 32'(N - 1 - k));
      check("t2.gap", 32'(n), (k == 0) ? 32'd1 : 32'd2);
      req[k] = 1'b0;
      serve(3);
      check("t2.turnaround", 32'(grant_valid), 32'd0);
    end
    tick();

    // Stale entry is discarded
    phase_tag = "t3";
    req = 4'b0001;
    wait_grant(4, n);
    check("t3.grant0", 32'(grant_id), 32'd0);
    req = 4'b0010;
    tick();
    req[3] = 1'b1;
    tick();
    check("t3.count2", 32'(queue_count), 32'd2);
    req[1] = 1'b0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t3.released", 32'(grant), 32'd0);
    tick();
    tick();
    check("t3.discard_no_grant", 32'(grant_valid), 32'd0);
    check("t3.discard_count", 32'(queue_count), 32'd1);
    tick();
    check("t3.grant3", 32'(grant), 32'h8);
    req[3] = 1'b0;
    serve(2);
    tick();

    // Continuous requester goes to the tail
    phase_tag = "t4";
    req = 4'b0001;
    wait_grant(4, n);
    check("t4.grant0", 32'(grant_id), 32'd0);
    req[1] = 1'b1;
    tick();
    serve(3);
    wait_grant(4, n);
    check("t4.fair_grant1", 32'(grant_id), 32'd1);
    check("t4.ch0_requeued", 32'(queue_count), 32'd1);
    req[1] = 1'b0;
    serve(2);
    wait_grant(4, n);
    check("t4.grant0_again", 32'(grant_id), 32'd0);
    req[0] = 1'b0;
    serve(2);
    tick();

    // Reset in the middle of a grant
    phase_tag = "t5";
    req = 4'b1111;
    wait_grant(4, n);
    check("t5.count3", 32'(queue_count), 32'd3);
    tick();
    do_reset();
    tick();
    check("t5.requeue_all", 32'(queue_count), 32'd4);
    tick();
    check("t5.grant0", 32'(grant_id), 32'd0);
    req[0] = 1'b0;
    serve(2);
    wait_grant(4, n);
    check("t5.grant1", 32'(grant_id), 32'd1);

`ifdef MEM_SCHED_TIMEOUT_EN
    // Grant revoked when done never arrives
    phase_tag = "t6";
    req = '0;
    do_reset();
    req = 4'b0011;
    tick();
    tick();
    check("t6.grant0", 32'(grant), 32'h1);
    repeat (TMO - 1) tick();
    check("t6.still_held", 32'(grant), 32'h1);
    tick();
    check("t6.revoked", 32'(grant), 32'd0);
    check("t6.err_pulse", 32'(timeout_err), 32'd1);
    tick();
    check("t6.err_clear", 32'(timeout_err), 32'd0);
    tick();
    check("t6.next_grant", 32'(grant), 32'h2);
    check("t6.ch0_blocked", 32'(queue_count), 32'd0);
    req  = '0;
    done = 1'b1;
    tick();
    done = 1'b0;
    req[0] = 1'b1;
    tick();
    check("t6.ch0_back", 32'(queue_count), 32'd1);
`endif

    // Randomized traffic
    phase_tag = "rand";
    req  = '0;
    done = 1'b0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_gnt == i) begin
          if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(3, 0) == 0) req[i] = 1'b1;
        end else if ($urandom_range(15, 0) == 0) begin
          req[i] = 1'b0;
        end
      end
      if (m_gnt >= 0) done = ($urandom_range(2, 0) == 0);
      else            done = ($urandom_range(7, 0) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
